// File: rtl/writeback_queue.sv
// writeback_queue: in-order write-back buffer in front of the 32x32 register file.
// It accepts ALU and load results, holds them in a circular FIFO and commits at
// most one of them to the register file on each clock edge. It also gives
// forwarding of the youngest queued write for one register index.
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   alu_valid/reg/data/ready  ALU result handshake
//   mem_valid/reg/data/ready  load result handshake (has priority over the ALU)
//   hold                      register-file write port busy; blocks the drain
//   WriteReg/WriteData        head entry sent to the register file (0 when empty)
//   RegWrite                  the head entry commits at this edge
//   fwd_reg/fwd_hit/fwd_data  forwarding lookup over the queued entries
//   count                     number of occupied entries
module writeback_queue #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_reg,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [ADDR_W-1:0]        mem_reg,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     mem_ready,
    input  logic                     hold,
    output logic [ADDR_W-1:0]        WriteReg,
    output logic [DATA_W-1:0]        WriteData,
    output logic                     RegWrite,
    input  logic [ADDR_W-1:0]        fwd_reg,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] ent_reg  [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    logic              not_full;
    logic              take_mem;
    logic              take_alu;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] enq_reg;
    logic [DATA_W-1:0] enq_data;

    // Handshake and enqueue selection. The readies look only at the registered
    // count, so a pop in the same cycle does not free a slot early.
    always_comb begin
        not_full  = (count != CNT_W'(DEPTH));
        mem_ready = not_full;
        alu_ready = not_full && !mem_valid;
        take_mem  = mem_valid && not_full;
        take_alu  = alu_valid && alu_ready;
        enq_reg   = take_mem ? mem_reg  : alu_reg;
        enq_data  = take_mem ? mem_data : alu_data;
        // Writes to r0 finish the handshake but are dropped.
        push      = (take_mem || take_alu) && (enq_reg != '0);
    end

    // Drain the head entry to the register file.
    always_comb begin
        RegWrite  = (count != '0) && !hold;
        pop       = RegWrite;
        WriteReg  = '0;
        WriteData = '0;
        if (count != '0) begin
            WriteReg  = ent_reg[rd_ptr];
            WriteData = ent_data[rd_ptr];
        end
    end

    // Walk the entries from oldest to youngest so that the youngest match wins.
    // The head is searched even in the cycle it commits.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (fwd_reg != '0) && (ent_reg[idx] == fwd_reg)) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data[idx];
            end
        end
    end

    // Pointers and occupancy. The pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entry storage has no reset; only the pointers and count define which entries are valid.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            ent_reg[wr_ptr]  <= enq_reg;
            ent_data[wr_ptr] <= enq_data;
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Testbench for writeback_queue. It runs directed scenarios and then randomized
// traffic. A queue-based reference model predicts every output in every cycle.
module tb_writeback_queue;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 4;

    logic              clock;
    logic              reset;
    logic              alu_valid, mem_valid, hold;
    logic [ADDR_W-1:0] alu_reg, mem_reg, fwd_reg;
    logic [DATA_W-1:0] alu_data, mem_data;
    logic              alu_ready, mem_ready, RegWrite, fwd_hit;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData, fwd_data;
    logic [$clog2(DEPTH):0] count;

    writeback_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .hold(hold), .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
        .fwd_reg(fwd_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t q[$];            // model: queued writes, oldest first
    int   checks = 0;
    int   errors = 0;
    bit   acc_alu, acc_mem;  // handshakes completed at the last edge
    int   commits;           // register-file commits seen by the model

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check every output against the model, advance one clock, then update the model.
    task automatic cycle();
        int          n;
        bit          e_rw, e_hit, e_mr, e_ar;
        logic [ADDR_W-1:0] e_wr;
        logic [DATA_W-1:0] e_wd, e_fd;
        n     = q.size();
        e_mr  = (n < DEPTH);
        e_ar  = (n < DEPTH) && !mem_valid;
        e_rw  = (n != 0) && !hold;
        e_wr  = (n != 0) ? q[0].r : '0;
        e_wd  = (n != 0) ? q[0].d : '0;
        e_hit = 1'b0;
        e_fd  = '0;
        if (fwd_reg != 0) begin
            for (int i = n - 1; i >= 0; i--) begin
                if (q[i].r == fwd_reg) begin
                    e_hit = 1'b1;
                    e_fd  = q[i].d;
                    break;
                end
            end
        end
        #1;
        chk("count", 64'(count), 64'(n));
        chk("mem_ready", 64'(mem_ready), 64'(e_mr));
        chk("alu_ready", 64'(alu_ready), 64'(e_ar));
        chk("RegWrite", 64'(RegWrite), 64'(e_rw));
        chk("WriteReg", 64'(WriteReg), 64'(e_wr));
        chk("WriteData", 64'(WriteData), 64'(e_wd));
        chk("fwd_hit", 64'(fwd_hit), 64'(e_hit));
        chk("fwd_data", 64'(fwd_data), 64'(e_fd));
        @(posedge clock);
        acc_mem = mem_valid && e_mr;
        acc_alu = alu_valid && e_ar;
        if (reset) begin
            q.delete();
        end else begin
            if (e_rw) begin
                void'(q.pop_front());
                commits++;
            end
            if (acc_mem && mem_reg != 0) q.push_back({mem_reg, mem_data});
            else if (acc_alu && alu_reg != 0) q.push_back({alu_reg, alu_data});
        end
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; mem_valid = 0;
        alu_reg = '0; mem_reg = '0; alu_data = '0; mem_data = '0;
    endtask

    initial begin
        commits = 0;
        fwd_reg = '0;
        hold    = 0;
        idle_inputs();

        // 1: reset held for two cycles while a load is offered.
        reset = 1; mem_valid = 1; mem_reg = 5'd3; mem_data = 32'h77;
        @(posedge clock); #1;
        chk("t1_rw_reset", 64'(RegWrite), 64'd0);
        cycle();
        chk("t1_rw_reset2", 64'(RegWrite), 64'd0);
        reset = 0; idle_inputs();
        #1;
        chk("t1_count", 64'(count), 64'd0);
        chk("t1_alu_ready", 64'(alu_ready), 64'd1);
        chk("t1_mem_ready", 64'(mem_ready), 64'd1);

        // 2: one ALU write commits one cycle later.
        alu_valid = 1; alu_reg = 5'd8; alu_data = 32'hDEADBEEF;
        cycle();
        idle_inputs();
        #1;
        chk("t2_rw", 64'(RegWrite), 64'd1);
        chk("t2_wreg", 64'(WriteReg), 64'd8);
        chk("t2_wdata", 64'(WriteData), 64'hDEADBEEF);
        chk("t2_count1", 64'(count), 64'd1);
        cycle();
        chk("t2_rw_off", 64'(RegWrite), 64'd0);
        chk("t2_count0", 64'(count), 64'd0);

        // 3: the load wins and the ALU result follows on the next edge.
        mem_valid = 1; mem_reg = 5'd9;  mem_data = 32'h1;
        alu_valid = 1; alu_reg = 5'd10; alu_data = 32'h2;
        #1;
        chk("t3_mem_ready", 64'(mem_ready), 64'd1);
        chk("t3_alu_ready", 64'(alu_ready), 64'd0);
        cycle();
        mem_valid = 0;
        cycle();
        chk("t3_alu_acc", 64'(acc_alu), 64'd1);
        alu_valid = 0;
        for (int i = 0; i < 3; i++) cycle();

        // 4: fill the queue under hold, then drain through the pointer wrap.
        hold = 1;
        begin
            int k;
            k = 1;
            for (int c = 0; c < 40 && (k <= 5 || q.size() != 0); c++) begin
                if (c == 8) hold = 0;
                alu_valid = (k <= 5);
                alu_reg   = ADDR_W'(k);
                alu_data  = 32'h100 + 32'(k);
                if (c == 6) begin
                    chk("t4_full", 64'(count), 64'd4);
                    chk("t4_alu_ready", 64'(alu_ready), 64'd0);
                end
                cycle();
                if (acc_alu && alu_valid) k++;
            end
            chk("t4_done", 64'(k), 64'd6);
        end
        idle_inputs();
        hold = 0;
        cycle();

        // 5: forwarding returns the youngest match.
        hold = 1;
        alu_valid = 1; alu_reg = 5'd5; alu_data = 32'h11; cycle();
        alu_reg = 5'd5; alu_data = 32'h22; cycle();
        alu_reg = 5'd6; alu_data = 32'h33; cycle();
        idle_inputs();
        fwd_reg = 5'd5; #1;
        chk("t5_hit5", 64'(fwd_hit), 64'd1);
        chk("t5_data5", 64'(fwd_data), 64'h22);
        cycle();
        fwd_reg = 5'd7; cycle();
        fwd_reg = 5'd0; cycle();
        hold = 0;
        fwd_reg = 5'd5;
        for (int i = 0; i < 4; i++) cycle();

        // 6: writes to r0 are dropped, and a reset discards queued writes.
        alu_valid = 1; alu_reg = 5'd0; alu_data = 32'hFFFF;
        #1;
        chk("t6_r0_ready", 64'(alu_ready), 64'd1);
        cycle();
        idle_inputs();
        chk("t6_r0_count", 64'(count), 64'd0);
        cycle();
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_reg = ADDR_W'(20 + i); alu_data = 32'(i); cycle();
        end
        idle_inputs();
        chk("t6_queued", 64'(count), 64'd3);
        reset = 1; cycle();
        reset = 0; hold = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t6_no_commit", 64'(RegWrite), 64'd0);
        end

        // Randomized traffic. Each producer keeps its offer until it is accepted.
        for (int c = 0; c < 600; c++) begin
            if (!mem_valid || acc_mem) begin
                mem_valid = ($urandom_range(0, 2) == 0);
                mem_reg   = ADDR_W'($urandom_range(0, 7));
                mem_data  = $urandom;
            end
            if (!alu_valid || acc_alu) begin
                alu_valid = ($urandom_range(0, 1) == 0);
                alu_reg   = ADDR_W'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            hold    = ($urandom_range(0, 9) < 4);
            fwd_reg = ADDR_W'($urandom_range(0, 7));
            reset   = ($urandom_range(0, 99) == 0);
            acc_alu = 0; acc_mem = 0;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
